// File: rtl/fir3_output_serializer.sv
// Rounds and saturates each lane of a parallel FIR output triplet to OUT_W bits,
// buffers triplets in a small FIFO and streams them out one sample per transfer.
module fir3_output_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  din1,
  input  logic signed [IN_W-1:0]  din2,
  input  logic signed [IN_W-1:0]  din3,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_flag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] MINV = -$signed((IN_W+1)'(2**(OUT_W-1)));

  logic signed [IN_W-1:0] din_arr [3];
  logic [3*OUT_W-1:0]     conv_word;
  logic [2:0]             lane_sat;

  assign din_arr[0] = din1;
  assign din_arr[1] = din2;
  assign din_arr[2] = din3;

  // One extra bit of headroom so the rounding add cannot wrap near the top of the range.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic signed [IN_W:0] ext;
      logic signed [IN_W:0] sum;
      logic signed [IN_W:0] shr;
      assign ext = {din_arr[gi][IN_W-1], din_arr[gi]};
      assign sum = ext + RND;
      assign shr = sum >>> SHIFT;
      assign lane_sat[gi] = (shr > MAXV) || (shr < MINV);
      assign conv_word[gi*OUT_W +: OUT_W] = (shr > MAXV) ? MAXV[OUT_W-1:0] :
                                            (shr < MINV) ? MINV[OUT_W-1:0] :
                                                           shr[OUT_W-1:0];
    end
  endgenerate

  logic [3*OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PW:0]        count_reg, count_next;
  logic [1:0]         lane_reg, lane_next;
  logic               sat_flag_reg, sat_flag_next;
  logic               full, empty, push, xfer, pop;
  logic [3*OUT_W-1:0] head;

  assign full      = (count_reg == (PW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign sat_flag  = sat_flag_reg;

  // Push uses only the registered full flag, so a same-cycle pop never frees a slot early.
  assign push = in_valid && !full && !rst;
  assign xfer = out_valid && out_ready;
  assign pop  = xfer && (lane_reg == 2'd2);
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= conv_word;
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    lane_next     = lane_reg;
    sat_flag_next = sat_flag_reg;
    if (push) begin
      wr_ptr_next   = wr_ptr_reg + 1'b1;
      sat_flag_next = sat_flag_reg | (|lane_sat);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (xfer) begin
      lane_next = (lane_reg == 2'd2) ? 2'd0 : lane_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      lane_reg     <= 2'd0;
      sat_flag_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      lane_reg     <= lane_next;
      sat_flag_reg <= sat_flag_next;
    end
  end

  always_comb begin
    dout = '0;
    if (out_valid) begin
      case (lane_reg)
        2'd0:    dout = head[0       +: OUT_W];
        2'd1:    dout = head[OUT_W   +: OUT_W];
        default: dout = head[2*OUT_W +: OUT_W];
      endcase
    end
  end

endmodule

// File: tb/tb_fir3_output_serializer.sv
// Scoreboard bench: accepted triplets are converted by a floor-division reference
// model into an expected sample queue that a negedge monitor drains and compares.
module tb_fir3_output_serializer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] din1, din2, din3;
  logic signed [15:0] dout;
  logic               out_valid;
  logic               out_ready;
  logic               sat_flag;

  int n_cmp = 0;
  int n_err = 0;
  logic signed [15:0] q [$];
  bit  sat_m = 1'b0;
  bit  armed = 1'b0;
  logic rst_q = 1'b0;
  bit  rand_done = 1'b0;

  fir3_output_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din2(din2), .din3(din3), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: round(x / 2^15) with halves toward +inf == floor((x + 2^14) / 2^15), then clamp.
  function automatic logic signed [15:0] model(input logic signed [63:0] x, output bit s);
    logic signed [127:0] v, qt;
    v  = 128'(x);
    v  = v + 128'sd16384;
    qt = v / 128'sd32768;
    if (v < 0 && qt * 128'sd32768 != v) qt = qt - 128'sd1;
    s = 1'b0;
    if (qt > 128'sd32767) begin s = 1'b1; return 16'sh7fff; end
    if (qt < -128'sd32768) begin s = 1'b1; return 16'sh8000; end
    return qt[15:0];
  endfunction

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    logic signed [15:0] e0, e1, e2;
    bit s0, s1, s2;
    int entries;
    if (rst) begin
      if (rst_q) begin
        check("reset_out_valid", out_valid, 0);
        check("reset_dout", dout, 0);
        check("reset_sat_flag", sat_flag, 0);
      end
      q.delete();
      sat_m = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      entries = (q.size() + 2) / 3;
      check("in_ready", in_ready, (entries < 4) ? 1 : 0);
      check("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      check("sat_flag", sat_flag, sat_m);
      if (out_valid) begin
        if (q.size() > 0) begin
          check("dout", dout, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        check("dout_idle", dout, 0);
      end
      if (in_valid && in_ready) begin
        e0 = model(din1, s0);
        e1 = model(din2, s1);
        e2 = model(din3, s2);
        q.push_back(e0);
        q.push_back(e1);
        q.push_back(e2);
        sat_m = sat_m | s0 | s1 | s2;
        $display("accept (%0d, %0d, %0d) -> expect %0d %0d %0d", din1, din2, din3, e0, e1, e2);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic signed [63:0] a, input logic signed [63:0] b,
                      input logic signed [63:0] c);
    bit ok;
    ok = 1'b0;
    din1 = a; din2 = b; din3 = c;
    in_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (in_ready && !rst) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got no accept, expected accept within 300 cycles");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] rnd();
    logic signed [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: v = v >>> 40;
      1: v = v >>> 30;
      2: v = v >>> 47;
      3: v = (64'($signed($urandom_range(0, 2000))) - 64'sd1000) * 64'sd32768
             + 64'sd16384 - 64'($urandom_range(0, 1));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    // Reset held two cycles with in_valid asserted: must be ignored.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    din1 = 64'sd100000; din2 = 64'sd200000; din3 = 64'sd300000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Rounding, then negative rounding with saturation.
    push(64'sd32768, 64'sd16384, 64'sd16383);
    drain();
    push(-64'sd16385, 64'sd1 <<< 40, -(64'sd1 <<< 40));
    drain();
    push(64'sd65536, -64'sd32768, 64'sd0);
    drain();

    // Backpressure: four fill the FIFO, the fifth must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(rnd() >>> 20, rnd() >>> 20, rnd() >>> 20);
    din1 = 64'sd5 <<< 15; din2 = 64'sd6 <<< 15; din3 = 64'sd7 <<< 15;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Simultaneous push and pop with count=2 and lane=2.
    out_ready = 1'b0;
    push(64'sd1 <<< 15, 64'sd2 <<< 15, 64'sd3 <<< 15);
    push(64'sd4 <<< 15, 64'sd5 <<< 15, 64'sd6 <<< 15);
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    push(64'sd7 <<< 15, 64'sd8 <<< 15, 64'sd9 <<< 15);
    drain();

    // Reset mid-stream with lane=1 and three triplets buffered.
    out_ready = 1'b0;
    push(64'sd11 <<< 15, 64'sd1 <<< 50, 64'sd13 <<< 15);
    push(64'sd14 <<< 15, 64'sd15 <<< 15, 64'sd16 <<< 15);
    push(64'sd17 <<< 15, 64'sd18 <<< 15, 64'sd19 <<< 15);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(64'sd21 <<< 15, 64'sd22 <<< 15, 64'sd23 <<< 15);
    drain();

    // Randomized traffic with random sink stalls.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      push(rnd(), rnd(), rnd());
    end
    rand_done = 1'b1;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
